// File: rtl/sop_sweep_checker_if.sv
// Stimulus/response bundle between the sweep checker and the SOP block plus its result outputs.
interface sop_sweep_checker_if;
    logic        start;
    logic        tt;
    logic        pp;
    logic        qq;
    logic        rr;
    logic        ss;
    logic        busy;
    logic        done;
    logic        pass;
    logic [4:0]  mismatch_count;
    logic [15:0] signature;
    logic [3:0]  first_fail_idx;
    logic        fail_valid;

    modport master (
        output start, tt,
        input  pp, qq, rr, ss, busy, done, pass, mismatch_count, signature,
               first_fail_idx, fail_valid
    );

    modport slave (
        input  start, tt,
        output pp, qq, rr, ss, busy, done, pass, mismatch_count, signature,
               first_fail_idx, fail_valid
    );
endinterface

// File: rtl/sop_sweep_checker.sv
// Exhaustive 16-combination sweep of a 4-input SOP block; samples tt at the end of each
// hold window, compares against a golden table and accumulates signature/mismatch results.
module sop_sweep_checker #(
    parameter int unsigned HOLD_CYCLES = 20,
    parameter logic [15:0] EXPECTED    = 16'h4644
) (
    input logic                 clk,
    input logic                 rst_n,
    sop_sweep_checker_if.slave  bus
);

    localparam logic [7:0] HoldLast = 8'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  hold_q, hold_d;
    logic [3:0]  pqrs_q, pqrs_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [4:0]  mm_q, mm_d;
    logic [15:0] sig_q, sig_d;
    logic [3:0]  ffi_q, ffi_d;
    logic        fv_q, fv_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            hold_q  <= '0;
            pqrs_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            mm_q    <= '0;
            sig_q   <= '0;
            ffi_q   <= '0;
            fv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            pqrs_q  <= pqrs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            mm_q    <= mm_d;
            sig_q   <= sig_d;
            ffi_q   <= ffi_d;
            fv_q    <= fv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        pqrs_d  = pqrs_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        mm_d    = mm_q;
        sig_d   = sig_q;
        ffi_d   = ffi_q;
        fv_d    = fv_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    state_d = StRun;
                    idx_d   = '0;
                    hold_d  = '0;
                    pqrs_d  = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    mm_d    = '0;
                    sig_d   = '0;
                    ffi_d   = '0;
                    fv_d    = 1'b0;
                end
            end
            StRun: begin
                if (hold_q == HoldLast) begin
                    sig_d[idx_q] = bus.tt;
                    if (bus.tt != EXPECTED[idx_q]) begin
                        mm_d = mm_q + 5'd1;
                        if (!fv_q) begin
                            ffi_d = idx_q;
                            fv_d  = 1'b1;
                        end
                    end
                    hold_d = '0;
                    if (idx_q != 4'd15) begin
                        idx_d  = idx_q + 4'd1;
                        pqrs_d = idx_q + 4'd1;
                    end else begin
                        // pass must reflect the index-15 sample taken on this same edge
                        state_d = StDone;
                        pqrs_d  = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (mm_d == 5'd0);
                    end
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.pp             = pqrs_q[3];
    assign bus.qq             = pqrs_q[2];
    assign bus.rr             = pqrs_q[1];
    assign bus.ss             = pqrs_q[0];
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.mismatch_count = mm_q;
    assign bus.signature      = sig_q;
    assign bus.first_fail_idx = ffi_q;
    assign bus.fail_valid     = fv_q;

endmodule

// File: tb/tb_sop_sweep_checker.sv
// Directed bench: two checker instances (HOLD_CYCLES 20 and 2) driven by a selectable tt source.
module tb_sop_sweep_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tt_mode = 0;  // 0: correct SOP, 1: stuck 0, 2: stuck 1
    int   passed = 0;
    int   total = 0;

    always #5 clk = ~clk;

    sop_sweep_checker_if a_if ();
    sop_sweep_checker_if b_if ();

    assign a_if.tt = (tt_mode == 0) ? ((a_if.rr & ~a_if.ss) | (a_if.pp & ~a_if.qq & ~a_if.rr & a_if.ss))
                   : (tt_mode == 2);
    assign b_if.tt = (b_if.rr & ~b_if.ss) | (b_if.pp & ~b_if.qq & ~b_if.rr & b_if.ss);

    sop_sweep_checker #(.HOLD_CYCLES(20), .EXPECTED(16'h4644)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if)
    );

    sop_sweep_checker #(.HOLD_CYCLES(2), .EXPECTED(16'h4644)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if)
    );

    // Pulse start on dut_a for one edge; returns 1 time unit after that edge.
    task automatic pulse_a();
        @(posedge clk); #1 a_if.start = 1'b1;
        @(posedge clk); #1 a_if.start = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] obs;
        rst_n = 1'b0;
        #1;
        obs = {a_if.pp, a_if.qq, a_if.rr, a_if.ss, a_if.busy, a_if.done, a_if.pass,
               a_if.mismatch_count, a_if.signature, a_if.first_fail_idx, a_if.fail_valid};
        total++;
        if (obs !== 32'h0) $display("FAIL reset_outputs: got %h expected %h", obs, 32'h0);
        else passed++;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_correct();
        tt_mode = 0;
        pulse_a();
        repeat (319) @(posedge clk);
        #1;
        total++;
        if ({a_if.busy, a_if.done} !== 2'b10)
            $display("FAIL latency_pre: got busy/done %b expected 10", {a_if.busy, a_if.done});
        else passed++;
        @(posedge clk); #1;
        total++;
        if ({a_if.busy, a_if.done, a_if.pass, a_if.fail_valid} !== 4'b0110)
            $display("FAIL correct_flags: got %b expected 0110",
                     {a_if.busy, a_if.done, a_if.pass, a_if.fail_valid});
        else passed++;
        total++;
        if (a_if.mismatch_count !== 5'd0 || a_if.signature !== 16'h4644)
            $display("FAIL correct_results: got mm=%0d sig=%h expected mm=0 sig=4644",
                     a_if.mismatch_count, a_if.signature);
        else passed++;
        total++;
        if ({a_if.pp, a_if.qq, a_if.rr, a_if.ss} !== 4'b0000)
            $display("FAIL done_pqrs: got %b expected 0000", {a_if.pp, a_if.qq, a_if.rr, a_if.ss});
        else passed++;
    endtask

    task automatic test_tt_zero();
        tt_mode = 1;
        pulse_a();
        repeat (320) @(posedge clk);
        #1;
        total++;
        if ({a_if.done, a_if.pass, a_if.fail_valid} !== 3'b101 || a_if.first_fail_idx !== 4'd2)
            $display("FAIL zero_flags: got done/pass/fv=%b ffi=%0d expected 101 ffi=2",
                     {a_if.done, a_if.pass, a_if.fail_valid}, a_if.first_fail_idx);
        else passed++;
        total++;
        if (a_if.mismatch_count !== 5'd5 || a_if.signature !== 16'h0000)
            $display("FAIL zero_results: got mm=%0d sig=%h expected mm=5 sig=0000",
                     a_if.mismatch_count, a_if.signature);
        else passed++;
    endtask

    task automatic test_tt_one();
        tt_mode = 2;
        pulse_a();
        repeat (320) @(posedge clk);
        #1;
        total++;
        if ({a_if.done, a_if.pass, a_if.fail_valid} !== 3'b101 || a_if.first_fail_idx !== 4'd0)
            $display("FAIL one_flags: got done/pass/fv=%b ffi=%0d expected 101 ffi=0",
                     {a_if.done, a_if.pass, a_if.fail_valid}, a_if.first_fail_idx);
        else passed++;
        total++;
        if (a_if.mismatch_count !== 5'd11 || a_if.signature !== 16'hFFFF)
            $display("FAIL one_results: got mm=%0d sig=%h expected mm=11 sig=ffff",
                     a_if.mismatch_count, a_if.signature);
        else passed++;
    endtask

    task automatic test_hold2();
        int bad = 0;
        @(posedge clk); #1 b_if.start = 1'b1;
        @(posedge clk); #1 b_if.start = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if ({b_if.pp, b_if.qq, b_if.rr, b_if.ss} !== 4'(k / 2) || b_if.busy !== 1'b1) begin
                if (bad == 0)
                    $display("FAIL hold2_seq: cycle %0d got pqrs=%b busy=%b expected pqrs=%0d busy=1",
                             k, {b_if.pp, b_if.qq, b_if.rr, b_if.ss}, b_if.busy, k / 2);
                bad++;
            end
            @(posedge clk); #1;
        end
        total++;
        if (bad != 0) ; else passed++;
        total++;
        if ({b_if.busy, b_if.done, b_if.pass} !== 3'b011 || b_if.signature !== 16'h4644)
            $display("FAIL hold2_end: got busy/done/pass=%b sig=%h expected 011 sig=4644",
                     {b_if.busy, b_if.done, b_if.pass}, b_if.signature);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] obs;
        tt_mode = 0;
        pulse_a();
        repeat (7 * 20 + 5) @(posedge clk);
        #1;
        total++;
        if ({a_if.pp, a_if.qq, a_if.rr, a_if.ss} !== 4'd7)
            $display("FAIL mid_index: got %0d expected 7", {a_if.pp, a_if.qq, a_if.rr, a_if.ss});
        else passed++;
        rst_n = 1'b0;
        #1;
        obs = {a_if.pp, a_if.qq, a_if.rr, a_if.ss, a_if.busy, a_if.done, a_if.pass,
               a_if.mismatch_count, a_if.signature, a_if.first_fail_idx, a_if.fail_valid};
        total++;
        if (obs !== 32'h0) $display("FAIL mid_reset_outputs: got %h expected %h", obs, 32'h0);
        else passed++;
        @(posedge clk); #1 rst_n = 1'b1;
        pulse_a();
        repeat (320) @(posedge clk);
        #1;
        total++;
        if ({a_if.done, a_if.pass} !== 2'b11 || a_if.signature !== 16'h4644)
            $display("FAIL mid_fresh_sweep: got done/pass=%b sig=%h expected 11 sig=4644",
                     {a_if.done, a_if.pass}, a_if.signature);
        else passed++;
    endtask

    task automatic test_back_to_back();
        tt_mode = 0;
        pulse_a();
        repeat (4) @(posedge clk);
        #1 a_if.start = 1'b1;
        @(posedge clk); #1 a_if.start = 1'b0;
        repeat (94) @(posedge clk);
        #1 a_if.start = 1'b1;
        @(posedge clk); #1 a_if.start = 1'b0;
        total++;
        if ({a_if.pp, a_if.qq, a_if.rr, a_if.ss} !== 4'd5 || a_if.busy !== 1'b1)
            $display("FAIL ignore_start_idx: got pqrs=%0d busy=%b expected 5 busy=1",
                     {a_if.pp, a_if.qq, a_if.rr, a_if.ss}, a_if.busy);
        else passed++;
        repeat (219) @(posedge clk);
        #1;
        total++;
        if ({a_if.busy, a_if.done} !== 2'b10)
            $display("FAIL ignore_start_pre: got busy/done %b expected 10", {a_if.busy, a_if.done});
        else passed++;
        @(posedge clk); #1;
        total++;
        if ({a_if.done, a_if.pass} !== 2'b11 || a_if.signature !== 16'h4644 ||
            a_if.mismatch_count !== 5'd0)
            $display("FAIL ignore_start_end: got done/pass=%b sig=%h mm=%0d expected 11 4644 0",
                     {a_if.done, a_if.pass}, a_if.signature, a_if.mismatch_count);
        else passed++;
        pulse_a();
        total++;
        if ({a_if.busy, a_if.done, a_if.pass} !== 3'b100 || a_if.signature !== 16'h0000)
            $display("FAIL restart_clear: got busy/done/pass=%b sig=%h expected 100 sig=0000",
                     {a_if.busy, a_if.done, a_if.pass}, a_if.signature);
        else passed++;
        repeat (319) @(posedge clk);
        #1;
        total++;
        if (a_if.done !== 1'b0)
            $display("FAIL restart_pre: got done=%b expected 0", a_if.done);
        else passed++;
        @(posedge clk); #1;
        total++;
        if ({a_if.done, a_if.pass} !== 2'b11 || a_if.signature !== 16'h4644)
            $display("FAIL restart_end: got done/pass=%b sig=%h expected 11 sig=4644",
                     {a_if.done, a_if.pass}, a_if.signature);
        else passed++;
    endtask

    initial begin
        a_if.start = 1'b0;
        b_if.start = 1'b0;
        test_reset();
        test_correct();
        test_tt_zero();
        test_tt_one();
        test_hold2();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sop_sweep_checker.md
Name: sop_sweep_checker

Overview:
Self-checking exhaustive stimulus/response stage for the 4-input sum-of-products block t = f(p,q,r,s).
- Sits directly upstream and downstream of that block: it drives pp/qq/rr/ss through all 16 combinations and samples the block's tt output.
- Compares each sample against the golden truth table, accumulates a 16-bit response signature and a mismatch count, and reports pass/fail.
- Replaces the hand-written #20 stimulus sequence with synthesizable, clocked sequencing.

Parameters:
HOLD_CYCLES, 20, clock cycles each input combination is held; legal range 2..255.
EXPECTED, 16'h4644, golden truth table; bit i = expected tt for {pp,qq,rr,ss} = i (ones at 2, 6, 9, 10, 14).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a sweep
tt  input  1  output of the SOP block under check
pp  output  1  SOP input p (MSB of combination index)
qq  output  1  SOP input q
rr  output  1  SOP input r
ss  output  1  SOP input s (LSB)
busy  output  1  high while a sweep is in progress
done  output  1  high once a sweep completes; held until next start
pass  output  1  valid when done; 1 if zero mismatches
mismatch_count  output  5  number of mismatching combinations, 0..16
signature  output  16  captured tt per index; bit i = sampled tt for index i
first_fail_idx  output  4  index of the first mismatch
fail_valid  output  1  high once any mismatch has been recorded in the current sweep

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - All outputs 0.
  - Internal idx = 0, hold_cnt = 0.
- State IDLE:
  - {pp,qq,rr,ss} = 4'b0000, busy = 0.
  - On a start-high edge: go to RUN, idx = 0, hold_cnt = 0, busy = 1.
  - Same edge clears done, pass, mismatch_count, signature, first_fail_idx and fail_valid.
- State RUN:
  - {pp,qq,rr,ss} = idx (registered outputs).
  - hold_cnt increments each cycle.
  - When hold_cnt == HOLD_CYCLES-1, the edge performs the sample:
    - signature[idx] <= tt.
    - If tt != EXPECTED[idx]: mismatch_count increments; if fail_valid is 0, first_fail_idx <= idx and fail_valid <= 1.
    - hold_cnt <= 0.
    - If idx != 15: idx <= idx+1. If idx == 15: go to DONE.
- Sampling point:
  - tt is sampled on the last cycle of each hold window, giving the combinational SOP block HOLD_CYCLES-1 cycles to settle.
  - No sample is taken on the first cycle of a window.
- State DONE:
  - busy = 0, done = 1.
  - pass = (final mismatch_count == 0), including the index-15 sample.
  - {pp,qq,rr,ss} return to 0000.
  - Results are held stable.
  - start restarts exactly as from IDLE, with the same clearing.
- Latency: start edge to done high = 16*HOLD_CYCLES cycles; busy is high for exactly 16*HOLD_CYCLES cycles.
- start while busy: ignored, with no restart and no effect on counters.
- Reset mid-sweep: immediate return to IDLE with all outputs 0; a subsequent start performs a full fresh sweep.
- Width rules:
  - mismatch_count is 5 bits and cannot overflow (maximum 16).
  - hold_cnt is 8 bits.
  - idx is 4 bits; it is never wrapped from 15 to 0 inside RUN.
- No output glitches: every output is driven from a flop.

Test Plan:
- Correct SOP model (tt = rr&~ss | pp&~qq&~rr&ss), HOLD_CYCLES=20, start pulse -> after 320 cycles done=1, pass=1, mismatch_count=0, signature=16'h4644, fail_valid=0.
- tt tied to 0 -> done after 320 cycles, pass=0, mismatch_count=5, signature=16'h0000, first_fail_idx=2, fail_valid=1.
- tt tied to 1 -> mismatch_count=11, signature=16'hFFFF, first_fail_idx=0, pass=0.
- HOLD_CYCLES=2, correct model; check pqrs per cycle -> each index held exactly 2 cycles in order 0..15, busy high for 32 cycles, pass=1.
- Correct model; rst_n low for 1 cycle at index 7, then start -> outputs 0 during reset, fresh sweep completes with pass=1, signature=16'h4644.
- Extra start pulses at cycles 5 and 100 of a sweep, then a start in DONE -> first sweep ends unchanged at cycle 320; the DONE-state start clears results and launches a second identical sweep.
